// File: rtl/bidir_in_filter.sv
// Per-pin input conditioning: 2-FF synchronizer, prescaled glitch filter (or bypass), sticky edge flags.
// Latency 2 cycles bypassed / N+1 sample ticks after sync when filtered; no backpressure, free-running.
module bidir_in_filter #(
  parameter int IOWidth       = 36,
  parameter int FilterWidth   = 8,
  parameter int PrescaleWidth = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [IOWidth-1:0]       pin_in,
  input  logic [IOWidth-1:0]       filt_en,
  input  logic [FilterWidth-1:0]   filt_len,
  input  logic [PrescaleWidth-1:0] prescale,
  input  logic [IOWidth-1:0]       clear_events,
  output logic [IOWidth-1:0]       filt_data,
  output logic [IOWidth-1:0]       rise_event,
  output logic [IOWidth-1:0]       fall_event,
  output logic                     tick
);

  logic [IOWidth-1:0]       sync1;
  logic [IOWidth-1:0]       sync2;
  logic [IOWidth-1:0]       filt_prev;
  logic [IOWidth-1:0]       filt_nxt;
  logic [PrescaleWidth-1:0] pcnt;
  logic [FilterWidth-1:0]   cnt     [IOWidth];
  logic [FilterWidth-1:0]   cnt_nxt [IOWidth];

  // The >= compare fires before cnt can pass filt_len, so cnt never wraps.
  always_comb begin
    filt_nxt = filt_data;
    for (int i = 0; i < IOWidth; i++) begin
      cnt_nxt[i] = cnt[i];
      if (!filt_en[i]) begin
        filt_nxt[i] = sync2[i];
        cnt_nxt[i]  = '0;
      end else if (sync2[i] == filt_data[i]) begin
        cnt_nxt[i] = '0;
      end else if (tick) begin
        if (cnt[i] >= filt_len) begin
          filt_nxt[i] = sync2[i];
          cnt_nxt[i]  = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1      <= '0;
      sync2      <= '0;
      filt_data  <= '0;
      filt_prev  <= '0;
      rise_event <= '0;
      fall_event <= '0;
      pcnt       <= '0;
      tick       <= 1'b0;
      for (int i = 0; i < IOWidth; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1     <= pin_in;
      sync2     <= sync1;
      filt_data <= filt_nxt;
      filt_prev <= filt_data;
      for (int i = 0; i < IOWidth; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      // A new edge beats a same-cycle clear so no event is ever lost.
      rise_event <= (rise_event & ~clear_events) | (filt_data & ~filt_prev);
      fall_event <= (fall_event & ~clear_events) | (~filt_data & filt_prev);
      if (pcnt == prescale) begin
        pcnt <= '0;
        tick <= 1'b1;
      end else begin
        pcnt <= pcnt + 1'b1;
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bidir_in_filter.sv
// Randomized and directed bench for bidir_in_filter against a tick-counting reference model.
module tb_bidir_in_filter;
  localparam int W = 36;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] pin_in;
  logic [W-1:0] filt_en;
  logic [7:0]   filt_len;
  logic [15:0]  prescale;
  logic [W-1:0] clear_events;
  logic [W-1:0] filt_data;
  logic [W-1:0] rise_event;
  logic [W-1:0] fall_event;
  logic         tick;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: ticks are a pure function of cycles since reset release; a pin
  // updates once it has differed from the output through more than filt_len ticks.
  logic [W-1:0] m_s1, m_s2, m_fd, m_prev, m_rise, m_fall;
  logic         m_tick;
  int           m_seen [W];
  int           m_c;

  bidir_in_filter dut (
    .clk(clk), .reset_n(reset_n), .pin_in(pin_in), .filt_en(filt_en),
    .filt_len(filt_len), .prescale(prescale), .clear_events(clear_events),
    .filt_data(filt_data), .rise_event(rise_event), .fall_event(fall_event), .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rand_mask(int unsigned one_in);
    logic [W-1:0] m;
    for (int i = 0; i < W; i++) m[i] = ($urandom_range(0, one_in - 1) == 0);
    return m;
  endfunction

  task automatic step();
    logic [W-1:0] fd_n;
    @(posedge clk);
    if (!reset_n) begin
      {m_s1, m_s2, m_fd, m_prev, m_rise, m_fall} = '0;
      m_tick = 1'b0;
      m_c = 0;
      for (int i = 0; i < W; i++) m_seen[i] = 0;
    end else begin
      fd_n = m_fd;
      for (int i = 0; i < W; i++) begin
        if (!filt_en[i]) begin
          fd_n[i] = m_s2[i];
          m_seen[i] = 0;
        end else if (m_s2[i] == m_fd[i]) begin
          m_seen[i] = 0;
        end else if (m_tick) begin
          m_seen[i] = m_seen[i] + 1;
          if (m_seen[i] > int'(filt_len)) begin
            fd_n[i] = m_s2[i];
            m_seen[i] = 0;
          end
        end
      end
      m_rise = (m_rise & ~clear_events) | (m_fd & ~m_prev);
      m_fall = (m_fall & ~clear_events) | (~m_fd & m_prev);
      m_prev = m_fd;
      m_fd   = fd_n;
      m_s2   = m_s1;
      m_s1   = pin_in;
      m_c    = m_c + 1;
      m_tick = ((m_c % (int'(prescale) + 1)) == 0);
    end
    #1;
  endtask

  task automatic do_reset(input logic [15:0] ps, input logic [7:0] len, input logic [W-1:0] en);
    reset_n = 1'b0; prescale = ps; filt_len = len; filt_en = en;
    pin_in = '0; clear_events = '0;
    step(); step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pin_in = '1; filt_en = '0; filt_len = 8'd0; prescale = 16'd0; clear_events = '0;
    for (int n = 0; n < 4; n++) begin
      step();
      vectors++;
      if ({filt_data, rise_event, fall_event, tick} !== '0) begin
        miscompares++;
        $display("FAIL reset_hold cyc %0d got %h want 0", n, {filt_data, rise_event, fall_event, tick});
      end
    end
    reset_n = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      step();
      vectors++;
      if ({filt_data, rise_event, fall_event, tick} !== {m_fd, m_rise, m_fall, m_tick}) begin
        miscompares++;
        $display("FAIL reset_release_model cyc %0d got %h want %h", n,
                 {filt_data, rise_event, fall_event, tick}, {m_fd, m_rise, m_fall, m_tick});
      end
      vectors++;
      if (filt_data !== ((n >= 3) ? {W{1'b1}} : {W{1'b0}})) begin
        miscompares++;
        $display("FAIL reset_release_data cyc %0d got %h", n, filt_data);
      end
      vectors++;
      if (rise_event !== ((n >= 4) ? {W{1'b1}} : {W{1'b0}})) begin
        miscompares++;
        $display("FAIL reset_release_rise cyc %0d got %h", n, rise_event);
      end
    end
  endtask

  task automatic test_bypass();
    do_reset(16'd0, 8'd7, '0);
    repeat (3) step();
    for (int t = 0; t < 2; t++) begin
      logic want;
      want = ~pin_in[5];
      pin_in[5] = want;
      for (int n = 1; n <= 3; n++) begin
        step();
        vectors++;
        if (filt_data[5] !== ((n == 3) ? want : ~want)) begin
          miscompares++;
          $display("FAIL bypass_latency toggle %0d cyc %0d got %b", t, n, filt_data[5]);
        end
      end
    end
    for (int n = 0; n < 40; n++) begin
      pin_in = pin_in ^ rand_mask(4);
      step();
      vectors++;
      if ({filt_data, rise_event, fall_event, tick} !== {m_fd, m_rise, m_fall, m_tick}) begin
        miscompares++;
        $display("FAIL bypass_random cyc %0d got %h want %h", n,
                 {filt_data, rise_event, fall_event, tick}, {m_fd, m_rise, m_fall, m_tick});
      end
    end
  endtask

  task automatic test_filter();
    do_reset(16'd0, 8'd4, '1);
    repeat (3) step();
    pin_in[0] = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      step();
      vectors++;
      if (filt_data[0] !== (n == 7)) begin
        miscompares++;
        $display("FAIL filter_step cyc %0d got %b want %b", n, filt_data[0], (n == 7));
      end
    end
    pin_in[1] = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      if (n == 5) pin_in[1] = 1'b0;
      step();
      vectors++;
      if ({filt_data[1], rise_event[1]} !== 2'b00) begin
        miscompares++;
        $display("FAIL filter_glitch cyc %0d got data %b rise %b want 0 0", n, filt_data[1], rise_event[1]);
      end
    end
  endtask

  task automatic test_prescale();
    int ticks;
    int d;
    bit seen;
    do_reset(16'd9, 8'd2, '1);
    ticks = 0;
    for (int n = 0; n < 100; n++) begin
      step();
      ticks += int'(tick);
      vectors++;
      if ({filt_data, rise_event, fall_event, tick} !== {m_fd, m_rise, m_fall, m_tick}) begin
        miscompares++;
        $display("FAIL prescale_model cyc %0d got %h want %h", n,
                 {filt_data, rise_event, fall_event, tick}, {m_fd, m_rise, m_fall, m_tick});
      end
    end
    vectors++;
    if (ticks != 10) begin
      miscompares++;
      $display("FAIL prescale_tick_count got %0d want 10", ticks);
    end
    repeat ($urandom_range(0, 9)) step();
    pin_in[3] = 1'b1;
    seen = 0; d = 0;
    for (int n = 1; n <= 60 && !seen; n++) begin
      step();
      if (filt_data[3]) begin seen = 1; d = n - 2; end
    end
    vectors++;
    if (!seen || d < 21 || d > 30) begin
      miscompares++;
      $display("FAIL prescale_step_delay seen %0d delay %0d want 21..30", seen, d);
    end
    pin_in[3] = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 16) pin_in[3] = 1'b1;
      step();
      vectors++;
      if ({filt_data[3], fall_event[3]} !== 2'b10) begin
        miscompares++;
        $display("FAIL prescale_glitch cyc %0d got data %b fall %b want 1 0", n, filt_data[3], fall_event[3]);
      end
    end
  endtask

  task automatic test_events();
    do_reset(16'd0, 8'd0, '0);
    repeat (3) step();
    pin_in[7] = 1'b1;
    repeat (5) step();
    pin_in[7] = 1'b0;
    repeat (5) step();
    vectors++;
    if ({rise_event[7], fall_event[7]} !== 2'b11) begin
      miscompares++;
      $display("FAIL events_sticky got rise %b fall %b want 1 1", rise_event[7], fall_event[7]);
    end
    clear_events[7] = 1'b1;
    step();
    clear_events[7] = 1'b0;
    vectors++;
    if ({rise_event[7], fall_event[7]} !== 2'b00) begin
      miscompares++;
      $display("FAIL events_clear got rise %b fall %b want 0 0", rise_event[7], fall_event[7]);
    end
    pin_in[7] = 1'b1;
    repeat (3) step();
    clear_events[7] = 1'b1;
    step();
    clear_events[7] = 1'b0;
    vectors++;
    if (rise_event[7] !== 1'b1) begin
      miscompares++;
      $display("FAIL events_set_beats_clear got %b want 1", rise_event[7]);
    end
    clear_events[7] = 1'b1;
    step();
    clear_events[7] = 1'b0;
    vectors++;
    if ({rise_event[7], fall_event[7]} !== 2'b00) begin
      miscompares++;
      $display("FAIL events_clear_alone got rise %b fall %b want 0 0", rise_event[7], fall_event[7]);
    end
  endtask

  task automatic test_midop();
    do_reset(16'd0, 8'd200, '1);
    repeat (3) step();
    pin_in[9] = 1'b1;
    repeat (52) step();
    vectors++;
    if (filt_data[9] !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_len_before got %b want 0", filt_data[9]);
    end
    filt_len = 8'd3;
    step();
    vectors++;
    if (filt_data[9] !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_len_lowered got %b want 1", filt_data[9]);
    end
    filt_len = 8'd200;
    pin_in[10] = 1'b1;
    repeat (30) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    vectors++;
    if ({filt_data, rise_event, fall_event} !== '0) begin
      miscompares++;
      $display("FAIL midop_reset got %h want 0", {filt_data, rise_event, fall_event});
    end
    for (int n = 0; n < 20; n++) begin
      step();
      vectors++;
      if ({filt_data, rise_event, fall_event, tick} !== {m_fd, m_rise, m_fall, m_tick} || fall_event !== '0) begin
        miscompares++;
        $display("FAIL midop_after_reset cyc %0d got %h want %h", n,
                 {filt_data, rise_event, fall_event, tick}, {m_fd, m_rise, m_fall, m_tick});
      end
    end
    filt_en[10] = 1'b0;
    step();
    vectors++;
    if ({filt_data[10], filt_data[9]} !== 2'b10) begin
      miscompares++;
      $display("FAIL midop_bypass_switch got %b%b want 10", filt_data[10], filt_data[9]);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      do_reset(16'($urandom_range(0, 3)), 8'($urandom_range(0, 5)), {$urandom, $urandom});
      for (int n = 0; n < 300; n++) begin
        pin_in = pin_in ^ rand_mask(6);
        clear_events = rand_mask(8);
        if ($urandom_range(0, 49) == 0) filt_len = 8'($urandom_range(0, 5));
        if ($urandom_range(0, 49) == 0) filt_en = filt_en ^ rand_mask(4);
        step();
        vectors++;
        if ({filt_data, rise_event, fall_event, tick} !== {m_fd, m_rise, m_fall, m_tick}) begin
          miscompares++;
          $display("FAIL random round %0d cyc %0d got %h want %h", r, n,
                   {filt_data, rise_event, fall_event, tick}, {m_fd, m_rise, m_fall, m_tick});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_filter();
    test_prescale();
    test_events();
    test_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bidir_in_filter.md
Name: bidir_in_filter

Overview:
- Input-side companion to the bidirectional I/O mux.
- Takes the raw values read back from the I/O pins and produces clean per-pin data for the function modules and the GPIO read register.
- Stages per pin: 2-FF synchronizer, then a programmable glitch filter with prescaled sample tick (or a per-pin bypass), then sticky rise/fall event flags.

Parameters:
- IOWidth, 36, number of pins.
- FilterWidth, 8, width of the filter length value and the per-pin counters.
- PrescaleWidth, 16, width of the sample-tick prescaler.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous active-low reset.
- pin_in  input  IOWidth  raw pin read data (asynchronous to clk).
- filt_en  input  IOWidth  per-pin filter enable; 0 = bypass.
- filt_len  input  FilterWidth  global filter length N, counted in sample ticks.
- prescale  input  PrescaleWidth  sample tick period minus 1.
- clear_events  input  IOWidth  per-pin clear of the rise/fall flags.
- filt_data  output  IOWidth  filtered pin state.
- rise_event  output  IOWidth  sticky 0->1 flag on filt_data.
- fall_event  output  IOWidth  sticky 1->0 flag on filt_data.
- tick  output  1  sample strobe, for debug and test.

Behaviour:
- Reset (reset_n=0 at a clk edge): sync1, sync2, filt_data, the per-pin counters, the prescaler, rise_event, fall_event and tick all go to 0.
- Reset asserted mid-count aborts the count. No event is generated by the reset itself.
- Synchronizer: sync1<=pin_in, sync2<=sync1, every cycle.
- Prescaler:
  - pcnt counts up by one per cycle.
  - When pcnt==prescale: tick=1 that cycle and pcnt<=0.
  - prescale=0 gives tick every cycle.
  - If prescale is lowered below the current pcnt, pcnt wraps through its maximum. This is accepted, with at most one long period.
- Bypass (filt_en[i]=0): filt_data[i]<=sync2[i] every cycle and cnt[i]<=0.
- Filter (filt_en[i]=1), evaluated per cycle:
  - If sync2[i]==filt_data[i]: cnt[i]<=0.
  - Else if tick and cnt[i]>=filt_len: filt_data[i]<=sync2[i], cnt[i]<=0.
  - Else if tick: cnt[i]<=cnt[i]+1.
  - Else: hold.
  - cnt saturates; it cannot wrap because the >= compare fires first.
- Glitch handling: any return of sync2 to filt_data before the update clears cnt. A pulse shorter than N+1 ticks is rejected.
- Latency, with prescale=0:
  - Pin stable from before edge k; bypass updates filt_data at edge k+2.
  - Filtered updates at edge k+2+N. N=0 matches bypass.
  - With prescale=P the update takes N+1 ticks after sync2 differs, i.e. between N*(P+1)+1 and (N+1)*(P+1) cycles.
- filt_len change mid-count takes effect on the next tick compare. Lowering it below cnt updates filt_data on that tick.
- filt_en 1->0 mid-count: the next cycle follows sync2 and cnt clears.
- Events, using registered previous filt_data:
  - rise_event[i] sets on a 0->1 change of filt_data[i]; fall_event[i] sets on a 1->0 change.
  - Flags hold until clear_events[i]=1.
  - A set and a clear in the same cycle: set wins and the flag stays 1.
  - A pin high at reset release yields a rise event once filt_data reaches 1. This is defined behaviour; software clears it.
- Fully registered outputs. All pins are independent; no cross-pin interaction.

Test Plan:
- Reset: pin_in=all 1s while reset_n=0 for 4 cycles -> filt_data=0, events=0, tick=0 throughout reset. Release -> filt_data=all 1s at edge 2, rise_event=all 1s one cycle later.
- Bypass: filt_en=0; toggle pin_in[5] at edge 10 -> filt_data[5] changes at edge 12; cnt stays 0.
- Filter: filt_en=all 1s, prescale=0, filt_len=4. pin_in[0] high from edge 20 -> filt_data[0]=1 at edge 26. A 4-cycle pulse on pin_in[1] -> filt_data[1] stays 0 and no event.
- Prescale: prescale=9, filt_len=2 -> tick every 10 cycles; a step on pin_in[3] reaches filt_data[3] after 21..30 cycles. A 15-cycle glitch is rejected.
- Events: a rise then a fall on pin 7 -> rise_event[7]=1 and fall_event[7]=1. clear_events[7] asserted in the same cycle as a new rise -> rise_event[7] stays 1. clear_events[7] alone -> both flags 0 next cycle.
- Mid-operation: filt_len lowered from 200 to 3 while cnt=50 -> update on the next tick. reset_n pulsed low mid-count -> cnt=0, filt_data=0, no event.
